// File: rtl/drc_axis_pxl_unpacker.sv
// AXI-Stream to pixel-stream downsizer. Each accepted beat is buffered and
// emitted one O_PXL_W pixel per cycle, least-significant pixel first.
module drc_axis_pxl_unpacker #(
   parameter int O_PXL_W       = 16,
   parameter int AXIS_DATA_W   = 256,
   parameter int AXIS_BYTE_AMT = AXIS_DATA_W / 8
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     tid,
   input  logic                     tdest,
   input  logic [AXIS_DATA_W-1:0]   tdata,
   input  logic [AXIS_BYTE_AMT-1:0] tkeep,
   input  logic [AXIS_BYTE_AMT-1:0] tstrb,
   input  logic                     tlast,
   input  logic                     tvalid,
   output logic                     tready,
   output logic [O_PXL_W-1:0]       o_pxl_dat,
   output logic                     o_pxl_last,
   output logic                     o_pxl_vld,
   input  logic                     o_pxl_rdy
);

   localparam int PXL_PER_BEAT  = AXIS_DATA_W / O_PXL_W;
   localparam int BYTES_PER_PXL = O_PXL_W / 8;
   localparam int CNT_W         = $clog2(PXL_PER_BEAT) + 1;

   typedef enum logic {EMPTY, DRAIN} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [AXIS_DATA_W-1:0] buf_dat;
   logic [CNT_W-1:0]       buf_cnt;
   logic [CNT_W-1:0]       idx;
   logic [CNT_W-1:0]       keep_cnt;
   logic [CNT_W-1:0]       load_cnt;
   logic                   buf_last;
   logic                   buf_vld;
   logic                   last_pxl;
   logic                   pxl_hs;
   logic                   beat_hs;
   logic                   unused_inputs;

   assign unused_inputs = ^{tid, tdest, tstrb, tkeep};

   assign buf_vld  = (state == DRAIN);
   assign last_pxl = (idx == buf_cnt - CNT_W'(1));
   assign pxl_hs   = buf_vld & o_pxl_rdy;
   assign tready   = aresetn & (~buf_vld | (pxl_hs & last_pxl));
   assign beat_hs  = tvalid & tready;

   // A tlast beat keeps one pixel per set lead keep bit; an all-zero keep
   // still yields one pixel so the frame end always reaches the display pipe.
   always_comb begin
      keep_cnt = '0;
      for (int k = 0; k < PXL_PER_BEAT; k++) begin
         if (tkeep[k*BYTES_PER_PXL]) begin
            keep_cnt = keep_cnt + CNT_W'(1);
         end
      end
      load_cnt = CNT_W'(PXL_PER_BEAT);
      if (tlast) begin
         load_cnt = (keep_cnt == '0) ? CNT_W'(1) : keep_cnt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (beat_hs) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pxl_hs && last_pxl && !beat_hs) begin
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // idx parks on the final pixel after draining so the output mux never
   // selects past the end of the buffer.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         buf_dat  <= '0;
         buf_cnt  <= '0;
         buf_last <= 1'b0;
         idx      <= '0;
      end else if (beat_hs) begin
         buf_dat  <= tdata;
         buf_cnt  <= load_cnt;
         buf_last <= tlast;
         idx      <= '0;
      end else if (pxl_hs && !last_pxl) begin
         idx      <= idx + CNT_W'(1);
      end
   end

   always_comb begin
      o_pxl_dat = '0;
      for (int k = 0; k < PXL_PER_BEAT; k++) begin
         if (idx == CNT_W'(k)) begin
            o_pxl_dat = buf_dat[k*O_PXL_W +: O_PXL_W];
         end
      end
   end

   assign o_pxl_vld  = buf_vld;
   assign o_pxl_last = buf_vld & buf_last & last_pxl;

endmodule
